uart_rx_ctrl: RTL and testbench

//  Sequencing FSM for the UART receiver. Times every bit from clk_RX using an edge

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_edge_bit_cnt.sv | 40 ++++
 rtl/uart_rx_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding,
// frame-layout constants, supported prescale values and a saturating counter helper.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_VALID  = 3'd5
   } rx_state_t;

   localparam int START_BITS = 1;
   localparam int PAR_BITS   = 1;
   localparam int STOP_BITS  = 1;

   localparam int PRESC_8  = 8;
   localparam int PRESC_16 = 16;
   localparam int PRESC_32 = 32;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter: edge wraps at P-1 and then
// advances the bit index; a synchronous clear parks both at zero.
module uart_rx_edge_bit_cnt
   import uart_rx_pkg::*;
#(
   parameter int PRESC_W = 6,
   parameter int BIT_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clr,
   input  logic [PRESC_W-1:0] i_presc,
   output logic [PRESC_W-1:0] o_edge_cnt,
   output logic [BIT_W-1:0]   o_bit_cnt,
   output logic               o_edge_last
);

   logic [PRESC_W-1:0] r_edge_cnt;
   logic [BIT_W-1:0]   r_bit_cnt;

   assign o_edge_last = (r_edge_cnt == i_presc - PRESC_W'(1));
   assign o_edge_cnt  = r_edge_cnt;
   assign o_bit_cnt   = r_bit_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (i_clr) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (o_edge_last) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
      end else begin
         r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing FSM: times each frame bit and pulses the datapath enables.
// Optional error counters are built when UART_RX_ERR_CNT_EN is defined.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic               i_clk_rx,
   input  logic               i_rst,
   input  logic               i_rx_in,
   input  logic [PRESC_W-1:0] i_prescale,
   input  logic               i_par_en,
   input  logic               i_str_glitch,
   input  logic               i_par_err,
   input  logic               i_stp_err,
   output logic               o_dat_samp_en,
   output logic [PRESC_W-1:0] o_edge_cnt,
   output logic               o_deser_en,
   output logic               o_str_chk_en,
   output logic               o_par_chk_en,
   output logic               o_stp_chk_en,
   output logic               o_data_valid
`ifdef UART_RX_ERR_CNT_EN
   ,
   input  logic               i_err_cnt_clr,
   output logic [7:0]         o_par_err_cnt,
   output logic [7:0]         o_stp_err_cnt,
   output logic [7:0]         o_glitch_cnt
`endif
);

   localparam int BIT_W = $clog2(START_BITS + DATA_WIDTH + PAR_BITS + STOP_BITS + 1);

   rx_state_t          r_state;
   logic [PRESC_W-1:0] r_presc;
   logic               r_par_en;
   logic               r_par_err_q;
   logic               r_dat_samp_en;
   logic               r_deser_en;
   logic               r_str_chk_en;
   logic               r_par_chk_en;
   logic               r_stp_chk_en;
   logic               r_data_valid;

   logic [PRESC_W-1:0] w_edge_cnt;
   logic [BIT_W-1:0]   w_bit_cnt;
   logic               w_edge_last;
   logic               w_cnt_clr;
   logic               w_pre_chk;
   logic               w_data_done;

   // Pulses are registered one edge early so they appear while edge_cnt reads P-2.
   assign w_cnt_clr   = (r_state == ST_IDLE) || (r_state == ST_VALID);
   assign w_pre_chk   = (w_edge_cnt == r_presc - PRESC_W'(3));
   assign w_data_done = (w_bit_cnt == BIT_W'(START_BITS + DATA_WIDTH - 1));

   uart_rx_edge_bit_cnt #(
      .PRESC_W (PRESC_W),
      .BIT_W   (BIT_W)
   ) u_cnt (
      .i_clk       (i_clk_rx),
      .i_rst       (i_rst),
      .i_clr       (w_cnt_clr),
      .i_presc     (r_presc),
      .o_edge_cnt  (w_edge_cnt),
      .o_bit_cnt   (w_bit_cnt),
      .o_edge_last (w_edge_last)
   );

   always_ff @(posedge i_clk_rx or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_presc       <= '0;
         r_par_en      <= 1'b0;
         r_par_err_q   <= 1'b0;
         r_dat_samp_en <= 1'b0;
         r_deser_en    <= 1'b0;
         r_str_chk_en  <= 1'b0;
         r_par_chk_en  <= 1'b0;
         r_stp_chk_en  <= 1'b0;
         r_data_valid  <= 1'b0;
      end else begin
         r_deser_en   <= 1'b0;
         r_str_chk_en <= 1'b0;
         r_par_chk_en <= 1'b0;
         r_stp_chk_en <= 1'b0;
         r_data_valid <= 1'b0;
         case (r_state)
            // VALID doubles as an idle slot so a back-to-back start bit is caught.
            ST_IDLE, ST_VALID: begin
               if (!i_rx_in) begin
                  r_state       <= ST_START;
                  r_presc       <= i_prescale;
                  r_par_en      <= i_par_en;
                  r_par_err_q   <= 1'b0;
                  r_dat_samp_en <= 1'b1;
               end else begin
                  r_state       <= ST_IDLE;
                  r_dat_samp_en <= 1'b0;
               end
            end
            ST_START: begin
               if (w_edge_last) begin
                  if (i_str_glitch) begin
                     r_state       <= ST_IDLE;
                     r_dat_samp_en <= 1'b0;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end else if (w_pre_chk) begin
                  r_str_chk_en <= 1'b1;
               end else begin
                  r_str_chk_en <= 1'b0;
               end
            end
            ST_DATA: begin
               if (w_edge_last && w_data_done) begin
                  r_state <= r_par_en ? ST_PARITY : ST_STOP;
               end else if (w_pre_chk) begin
                  r_deser_en <= 1'b1;
               end else begin
                  r_deser_en <= 1'b0;
               end
            end
            ST_PARITY: begin
               if (w_edge_last) begin
                  r_par_err_q <= i_par_err;
                  r_state     <= ST_STOP;
               end else if (w_pre_chk) begin
                  r_par_chk_en <= 1'b1;
               end else begin
                  r_par_chk_en <= 1'b0;
               end
            end
            ST_STOP: begin
               if (w_edge_last) begin
                  if (!i_stp_err && !r_par_err_q) begin
                     r_state      <= ST_VALID;
                     r_data_valid <= 1'b1;
                  end else begin
                     r_state       <= ST_IDLE;
                     r_dat_samp_en <= 1'b0;
                  end
               end else if (w_pre_chk) begin
                  r_stp_chk_en <= 1'b1;
               end else begin
                  r_stp_chk_en <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_dat_samp_en <= 1'b0;
            end
         endcase
      end
   end

   assign o_dat_samp_en = r_dat_samp_en;
   assign o_edge_cnt    = w_edge_cnt;
   assign o_deser_en    = r_deser_en;
   assign o_str_chk_en  = r_str_chk_en;
   assign o_par_chk_en  = r_par_chk_en;
   assign o_stp_chk_en  = r_stp_chk_en;
   assign o_data_valid  = r_data_valid;

`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] r_par_err_cnt;
   logic [7:0] r_stp_err_cnt;
   logic [7:0] r_glitch_cnt;
   logic       w_glitch_evt;
   logic       w_par_evt;
   logic       w_stp_evt;

   assign w_glitch_evt = (r_state == ST_START) && w_edge_last && i_str_glitch;
   assign w_par_evt    = (r_state == ST_STOP) && w_edge_last && r_par_err_q;
   assign w_stp_evt    = (r_state == ST_STOP) && w_edge_last && i_stp_err;

   always_ff @(posedge i_clk_rx or posedge i_rst) begin
      if (i_rst) begin
         r_par_err_cnt <= 8'd0;
         r_stp_err_cnt <= 8'd0;
         r_glitch_cnt  <= 8'd0;
      end else if (i_err_cnt_clr) begin
         r_par_err_cnt <= 8'd0;
         r_stp_err_cnt <= 8'd0;
         r_glitch_cnt  <= 8'd0;
      end else begin
         if (w_par_evt)    r_par_err_cnt <= sat_inc8(r_par_err_cnt);
         if (w_stp_evt)    r_stp_err_cnt <= sat_inc8(r_stp_err_cnt);
         if (w_glitch_evt) r_glitch_cnt  <= sat_inc8(r_glitch_cnt);
      end
   end

   assign o_par_err_cnt = r_par_err_cnt;
   assign o_stp_err_cnt = r_stp_err_cnt;
   assign o_glitch_cnt  = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected pulse events come from frame arithmetic;
// a monitor pops and compares them. Covers UART_RX_ERR_CNT_EN when defined.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       par_en = 1'b0;
   logic       str_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
   logic       dat_samp_en, deser_en, str_chk_en, par_chk_en, stp_chk_en, data_valid;
   logic [5:0] edge_cnt;
`ifdef UART_RX_ERR_CNT_EN
   logic       err_cnt_clr = 1'b0;
   logic [7:0] par_err_cnt, stp_err_cnt, glitch_cnt;
`endif

   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
      .i_clk_rx      (clk),
      .i_rst         (rst),
      .i_rx_in       (rx_in),
      .i_prescale    (prescale),
      .i_par_en      (par_en),
      .i_str_glitch  (str_glitch),
      .i_par_err     (par_err),
      .i_stp_err     (stp_err),
      .o_dat_samp_en (dat_samp_en),
      .o_edge_cnt    (edge_cnt),
      .o_deser_en    (deser_en),
      .o_str_chk_en  (str_chk_en),
      .o_par_chk_en  (par_chk_en),
      .o_stp_chk_en  (stp_chk_en),
      .o_data_valid  (data_valid)
`ifdef UART_RX_ERR_CNT_EN
      ,
      .i_err_cnt_clr (err_cnt_clr),
      .o_par_err_cnt (par_err_cnt),
      .o_stp_err_cnt (stp_err_cnt),
      .o_glitch_cnt  (glitch_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 str_chk_en, 1 deser_en, 2 par_chk_en, 3 stp_chk_en, 4 data_valid
   typedef struct {
      int kind;
      int at;
      int p;
   } ev_t;
   ev_t   exp_q[$];
   string kname [0:4] = '{"str_chk_en", "deser_en", "par_chk_en", "stp_chk_en", "data_valid"};

   int n_tests = 0;
   int n_fail  = 0;
   int ready   = 0;
   int m_glitch = 0, m_par = 0, m_stp = 0;
   logic cfg_glitch = 1'b0, cfg_perr = 1'b0, cfg_serr = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // Check results are presented exactly in the cycle after each check enable; otherwise noise.
   logic pend_s = 1'b0, pend_p = 1'b0, pend_t = 1'b0;
   logic hold_s = 1'b0, hold_p = 1'b0, hold_t = 1'b0;
   always @(posedge clk) begin
      #2;
      str_glitch = pend_s ? hold_s : 1'($urandom_range(0, 1));
      par_err    = pend_p ? hold_p : 1'($urandom_range(0, 1));
      stp_err    = pend_t ? hold_t : 1'($urandom_range(0, 1));
      pend_s = str_chk_en;  hold_s = cfg_glitch;
      pend_p = par_chk_en;  hold_p = cfg_perr;
      pend_t = stp_chk_en;  hold_t = cfg_serr;
   end

   // Monitor: every output pulse must match the head of the expected-event queue.
   always @(negedge clk) begin
      logic [4:0] pul;
      ev_t        e;
      if (!rst) begin
         pul = {data_valid, stp_chk_en, par_chk_en, deser_en, str_chk_en};
         for (int k = 0; k < 5; k++) begin
            if (pul[k]) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected %s: got 1, expected 0 (cycle %0d)", kname[k], cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("event kind", k, e.kind);
                  check("event cycle", cyc, e.at);
                  check("edge_cnt at event", int'(edge_cnt), (e.kind == 4) ? 0 : e.p - 2);
                  check("dat_samp_en at event", int'(dat_samp_en), 1);
               end
            end
         end
      end
   end

   task automatic push_ev(input int kind, input int at, input int p, input int lim);
      ev_t e;
      if (lim < 0 || at <= lim) begin
         e.kind = kind;
         e.at   = at;
         e.p    = p;
         exp_q.push_back(e);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " dat_samp_en"}, int'(dat_samp_en), 0);
      check({tag, " edge_cnt"},    int'(edge_cnt),    0);
      check({tag, " deser_en"},    int'(deser_en),    0);
      check({tag, " str_chk_en"},  int'(str_chk_en),  0);
      check({tag, " par_chk_en"},  int'(par_chk_en),  0);
      check({tag, " stp_chk_en"},  int'(stp_chk_en),  0);
      check({tag, " data_valid"},  int'(data_valid),  0);
   endtask

   // One frame on the line. Frame bit i occupies oversample cycles [i*P, i*P+P) after the
   // detecting edge t0; each check pulse appears at offset P-2 of its bit, data_valid at N*P.
   task automatic send_frame(input int p, input bit pe, input logic [7:0] data, input bit glitch,
                             input int low_cyc, input bit perr, input bit serr, input bit b2b,
                             input int abort_bit);
      int   t0, nbits, lim;
      logic line [0:10];
      if (!b2b) begin
         while (cyc + 1 < ready) @(negedge clk);
         repeat (1 + $urandom_range(0, 3)) @(negedge clk);
         check("idle dat_samp_en", int'(dat_samp_en), 0);
         check("idle edge_cnt", int'(edge_cnt), 0);
      end
      prescale   = 6'(p);
      par_en     = pe;
      cfg_glitch = glitch;
      cfg_perr   = perr;
      cfg_serr   = serr;
      rx_in      = 1'b0;
      t0    = (cyc + 1 > ready) ? cyc + 1 : ready;
      nbits = pe ? 11 : 10;
      lim   = (abort_bit >= 0) ? t0 + abort_bit * p + 2 : -1;
      push_ev(0, t0 + p - 2, p, lim);
      if (glitch) begin
         m_glitch++;
         ready = t0 + p + 1;
         repeat (low_cyc) @(negedge clk);
         rx_in    = 1'b1;
         prescale = 6'(8 << $urandom_range(0, 2));
         par_en   = 1'($urandom_range(0, 1));
         while (cyc + 1 < ready) @(negedge clk);
      end else begin
         for (int i = 1; i <= 8; i++) push_ev(1, t0 + i * p + p - 2, p, lim);
         if (pe) push_ev(2, t0 + 9 * p + p - 2, p, lim);
         push_ev(3, t0 + (nbits - 1) * p + p - 2, p, lim);
         if (!(pe && perr) && !serr) push_ev(4, t0 + nbits * p, p, lim);
         if (lim < 0) begin
            if (pe && perr) m_par++;
            if (serr) m_stp++;
         end
         ready = t0 + nbits * p + 1;
         line[0] = 1'b0;
         for (int i = 0; i < 8; i++) line[i + 1] = data[i];
         line[9]  = ^data;
         line[nbits - 1] = 1'b1;
         for (int c = 0; c < nbits * p; c++) begin
            rx_in = line[c / p];
            if (c == p) begin
               prescale = 6'(8 << $urandom_range(0, 2));
               par_en   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (lim >= 0 && cyc == lim) break;
         end
         if (lim >= 0) begin
            #1;
            rst   = 1'b1;
            rx_in = 1'b1;
            @(negedge clk);
            check_all_zero("after abort");
            #1;
            rst = 1'b0;
            ready = cyc + 1;
            m_glitch = 0;
            m_par    = 0;
            m_stp    = 0;
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      bit pe, b2b;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst   = 1'b0;
      ready = cyc + 1;

      send_frame(8, 1'b0, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
      send_frame(16, 1'b1, 8'($urandom), 1'b0, 0, 1'b1, 1'b0, 1'b0, -1);
      send_frame(32, 1'b0, 8'h00, 1'b1, 10, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8, 1'b0, 8'($urandom), 1'b0, 0, 1'b0, 1'b1, 1'b0, -1);
      send_frame(8, 1'b0, 8'h3C, 1'b0, 0, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8, 1'b0, 8'($urandom), 1'b0, 0, 1'b0, 1'b0, 1'b0, 5);
      send_frame(8, 1'b0, 8'hFF, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);

      for (int f = 0; f < 40; f++) begin
         r   = int'($urandom_range(0, 9));
         pe  = 1'($urandom_range(0, 1));
         b2b = (r >= 6);
         if (r == 0)
            send_frame(8 << $urandom_range(0, 2), pe, 8'($urandom), 1'b1,
                       int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0, -1);
         else
            send_frame(8 << $urandom_range(0, 2), pe, 8'($urandom), 1'b0, 0,
                       (r == 1), (r == 2), b2b, -1);
      end

      while (cyc < ready + 4) @(negedge clk);
      check("events outstanding", exp_q.size(), 0);

`ifdef UART_RX_ERR_CNT_EN
      check("glitch_cnt", int'(glitch_cnt), sat(m_glitch));
      check("par_err_cnt", int'(par_err_cnt), sat(m_par));
      check("stp_err_cnt", int'(stp_err_cnt), sat(m_stp));
      err_cnt_clr = 1'b1;
      @(negedge clk);
      err_cnt_clr = 1'b0;
      check("glitch_cnt cleared", int'(glitch_cnt), 0);
      check("par_err_cnt cleared", int'(par_err_cnt), 0);
      check("stp_err_cnt cleared", int'(stp_err_cnt), 0);
      m_glitch = 0;
      for (int g = 0; g < 300; g++)
         send_frame(8, 1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 1'b0, -1);
      @(negedge clk);
      check("glitch_cnt saturated", int'(glitch_cnt), sat(m_glitch));
      err_cnt_clr = 1'b1;
      send_frame(8, 1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 1'b0, -1);
      @(negedge clk);
      err_cnt_clr = 1'b0;
      check("glitch_cnt clear priority", int'(glitch_cnt), 0);
      check("events outstanding after counters", exp_q.size(), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
